// File: rtl/coin_acceptor.sv
// Coin/cancel front end: sync, debounce and edge-detect three raw inputs, queue events, emit one-cycle codes.
// Optional COIN_TALLY_EN adds a saturating half-unit tally of popped events.
module coin_acceptor #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sns_half,
  input  logic                     sns_one,
  input  logic                     btn_cancel,
  output logic [1:0]               coin,
  output logic                     jam,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0]               tally
`endif
);

  localparam int unsigned NSRC = 3;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);

  logic [NSRC-1:0] raw, sync1, sync2, deb, deb_d, pend, rise, psel, grant;
  logic [CW-1:0]   cnt [NSRC];
  logic [1:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [1:0]      push_code;
  logic            pop, push, full;

  // Bit index is arbitration priority: half, one, cancel.
  assign raw = {btn_cancel, sns_one, sns_half};

  // Two-flop synchronizers and per-source debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NSRC; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = deb & ~deb_d;
  assign pop  = (fifo_cnt != '0);
  assign full = (fifo_cnt == CNTW'(DEPTH));

  // Fixed-priority arbiter over pending sources.
  always_comb begin
    psel      = '0;
    push_code = 2'd0;
    if (pend[0]) begin
      psel      = 3'b001;
      push_code = 2'd1;
    end else if (pend[1]) begin
      psel      = 3'b010;
      push_code = 2'd2;
    end else if (pend[2]) begin
      psel      = 3'b100;
      push_code = 2'd3;
    end
  end

  assign push  = (|pend) && (!full || pop);
  assign grant = push ? psel : '0;

  // A rise on a still-pending, ungranted source is lost and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      jam  <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | rise;
      if (|(rise & pend & ~grant)) jam <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      coin     <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      coin     <= pop ? mem[rd_ptr] : 2'd0;
      fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
    end
  end

`ifdef COIN_TALLY_EN
  logic [1:0] tally_inc;
  logic [8:0] tally_sum;

  // Half adds one, one adds two, cancel adds nothing; saturate at 255.
  assign tally_inc = (mem[rd_ptr] == 2'd3) ? 2'd0 : mem[rd_ptr];
  assign tally_sum = 9'(tally) + 9'(tally_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      tally <= 8'd0;
    end else if (pop) begin
      tally <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, forced back-pressure sequences and random stimulus vs a queue model.
module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       sns_half, sns_one, btn_cancel;
  logic [1:0] coin;
  logic       jam;
  logic [2:0] fifo_cnt;
`ifdef COIN_TALLY_EN
  logic [7:0] tally;
`endif

  coin_acceptor #(.DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sns_half(sns_half), .sns_one(sns_one),
    .btn_cancel(btn_cancel), .coin(coin), .jam(jam), .fifo_cnt(fifo_cnt)
`ifdef COIN_TALLY_EN
    , .tally(tally)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: event queue, pending flags, sample history windows.
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_deb [3];
  bit m_rose [3];
  bit m_pend [3];
  bit m_hist [3][DEB];
  int m_q[$];
  int m_coin;
  bit m_jam;
  int m_tally;
  bit m_block;

  function automatic void model_edge(input bit r, input bit [2:0] raw);
    bit pop, pushed, all_diff;
    int psel, popped;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_rose[i] = 0; m_pend[i] = 0;
        for (int j = 0; j < DEB; j++) m_hist[i][j] = 0;
      end
      m_q.delete();
      m_coin = 0; m_jam = 0; m_tally = 0;
      return;
    end
    pop = !m_block && (m_q.size() > 0);
    psel = -1;
    for (int i = 2; i >= 0; i--) if (m_pend[i]) psel = i;
    pushed = (psel >= 0) && ((m_q.size() < DEPTH) || pop);
    popped = 0;
    if (pop) popped = m_q.pop_front();
    if (pushed) begin
      m_q.push_back(psel + 1);
      m_pend[psel] = 0;
    end
    for (int i = 0; i < 3; i++)
      if (m_rose[i]) begin
        if (m_pend[i]) m_jam = 1;
        else m_pend[i] = 1;
      end
    m_coin = popped;
    if (popped == 1) m_tally = (m_tally + 1 > 255) ? 255 : m_tally + 1;
    if (popped == 2) m_tally = (m_tally + 2 > 255) ? 255 : m_tally + 2;
    // Debounced level flips once the last DEB synced samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = m_s2[i];
      all_diff = 1;
      for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_deb[i]) all_diff = 0;
      m_rose[i] = all_diff && !m_deb[i];
      if (all_diff) m_deb[i] = !m_deb[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit [2:0] raw);
    reset = r;
    sns_half = raw[0];
    sns_one = raw[1];
    btn_cancel = raw[2];
    @(posedge clk);
    model_edge(r, raw);
    #1;
  endtask

  task automatic check_model();
    cmp("model_coin", int'(coin), m_coin);
    cmp("model_jam", int'(jam), int'(m_jam));
    cmp("model_fifo_cnt", int'(fifo_cnt), m_q.size());
`ifdef COIN_TALLY_EN
    cmp("model_tally", int'(tally), m_tally);
`endif
  endtask

  task automatic pulse(input bit [2:0] raw, input int hi, input int lo);
    for (int k = 0; k < hi + lo; k++) begin
      drive(1'b0, (k < hi) ? raw : 3'b000);
      check_model();
    end
  endtask

  typedef struct {
    bit r; bit [2:0] raw; int coin; int jam; int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input bit [2:0] raw, input int c, input int j, input int n);
    vec_t v;
    v.r = r; v.raw = raw; v.coin = c; v.jam = j; v.cnt = n;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[$];
    int got[$];
    bit [2:0] lvl;
    int rem [3];
    bit r;
    m_block = 0;
    reset = 1'b1; sns_half = 1'b0; sns_one = 1'b0; btn_cancel = 1'b0;

    // Reset, single half pulse latency, glitch rejection, simultaneous rises.
    add(1, 3'b000, 0, 0, 0);
    add(1, 3'b000, 0, 0, 0);
    for (int e = 0; e < 22; e++)
      add(0, (e < 10) ? 3'b001 : 3'b000, (e == 8) ? 1 : 0, 0, (e == 7) ? 1 : 0);
    for (int e = 0; e < 15; e++)
      add(0, (e < 3) ? 3'b010 : 3'b000, 0, 0, 0);
    for (int e = 0; e < 26; e++)
      add(0, (e < 12) ? 3'b111 : 3'b000,
          (e == 8) ? 1 : (e == 9) ? 2 : (e == 10) ? 3 : 0, 0,
          (e >= 7 && e <= 9) ? 1 : 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].raw);
      cmp("tbl_coin", int'(coin), tbl[i].coin);
      cmp("tbl_jam", int'(jam), tbl[i].jam);
      cmp("tbl_fifo_cnt", int'(fifo_cnt), tbl[i].cnt);
      check_model();
    end

    // Blocked output: four queued, two pending, a seventh edge on pending half jams.
    force dut.pop = 1'b0;
    m_block = 1;
    for (int k = 0; k < 7; k++) pulse((k % 2 == 0) ? 3'b001 : 3'b010, 6, 6);
    cmp("full_fifo_cnt", int'(fifo_cnt), 4);
    cmp("jam_set", int'(jam), 1);
    release dut.pop;
    m_block = 0;
    exp_seq = '{1, 2, 1, 2, 1, 2};
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 3'b000);
      check_model();
      if (coin != 2'd0) got.push_back(int'(coin));
    end
    cmp("drain_count", got.size(), 6);
    foreach (exp_seq[i]) cmp("drain_order", (i < got.size()) ? got[i] : -1, exp_seq[i]);
    cmp("jam_sticky", int'(jam), 1);

    // Reset while two entries are queued discards them.
    drive(1'b1, 3'b000);
    check_model();
    force dut.pop = 1'b0;
    m_block = 1;
    pulse(3'b001, 6, 6);
    pulse(3'b010, 6, 6);
    cmp("two_queued", int'(fifo_cnt), 2);
    drive(1'b1, 3'b000);
    release dut.pop;
    m_block = 0;
    cmp("rst_coin", int'(coin), 0);
    cmp("rst_fifo_cnt", int'(fifo_cnt), 0);
    cmp("rst_jam", int'(jam), 0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 3'b000);
      cmp("no_stale_coin", int'(coin), 0);
      check_model();
    end

`ifdef COIN_TALLY_EN
    drive(1'b1, 3'b000);
    pulse(3'b001, 6, 6); cmp("tally_half", int'(tally), 1);
    pulse(3'b010, 6, 6); cmp("tally_one_a", int'(tally), 3);
    pulse(3'b010, 6, 6); cmp("tally_one_b", int'(tally), 5);
    pulse(3'b100, 6, 6); cmp("tally_cancel", int'(tally), 5);
    drive(1'b1, 3'b000);
    for (int k = 0; k < 130; k++) pulse(3'b010, 6, 6);
    cmp("tally_sat", int'(tally), 255);
`endif

    // Random raw levels, occasional resets and back-pressure windows.
    drive(1'b1, 3'b000);
    lvl = 3'b000;
    for (int i = 0; i < 3; i++) rem[i] = $urandom_range(1, 14);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = ~lvl[i];
          rem[i] = $urandom_range(1, 14);
        end else begin
          rem[i]--;
        end
      end
      if ($urandom_range(0, 79) == 0) begin
        if (m_block) begin
          release dut.pop;
          m_block = 0;
        end else begin
          force dut.pop = 1'b0;
          m_block = 1;
        end
      end
      r = ($urandom_range(0, 299) == 0);
      drive(r, lvl);
      check_model();
    end
    if (m_block) begin
      release dut.pop;
      m_block = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
